// File: rtl/conv_channel_injector_if.sv
// conv_channel_injector_if: symbol stream, channel controls and statistics between bench/encoder and the channel model
interface conv_channel_injector_if #(parameter int W = 2, parameter int CW = 16);
  logic          valid_i;
  logic [W-1:0]  sym_i;
  logic [1:0]    mode_i;
  logic [W-1:0]  err_mask_i;
  logic [7:0]    burst_len_i;
  logic [7:0]    period_i;
  logic          clear_i;
  logic          valid_o;
  logic [W-1:0]  sym_o;
  logic          err_o;
  logic [CW-1:0] sym_err_ct_o;
  logic [CW-1:0] bit_err_ct_o;
  logic [CW-1:0] word_ct_o;
  logic          window_done_o;
  modport master (
    output valid_i, sym_i, mode_i, err_mask_i, burst_len_i, period_i, clear_i,
    input  valid_o, sym_o, err_o, sym_err_ct_o, bit_err_ct_o, word_ct_o, window_done_o
  );
  modport slave (
    input  valid_i, sym_i, mode_i, err_mask_i, burst_len_i, period_i, clear_i,
    output valid_o, sym_o, err_o, sym_err_ct_o, bit_err_ct_o, word_ct_o, window_done_o
  );
endinterface

// File: rtl/conv_channel_injector.sv
// conv_channel_injector: registered channel model corrupting encoder symbols (clean/random/burst/periodic) with saturating error statistics; ports: clk, rst_n, bus (slave)
module conv_channel_injector #(
  parameter int          W      = 2,
  parameter int          N      = 4,
  parameter int          WINDOW = 256,
  parameter int          CW     = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input logic clk,
  input logic rst_n,
  conv_channel_injector_if.slave bus
);
  localparam logic [15:0] SEED_V = (SEED == 16'h0) ? 16'hACE1 : SEED;
  typedef enum logic {IDLE, BURST} state_t;
  state_t st_q, st_d;
  logic [7:0] rem_q, rem_d, phase_q, phase_d;
  logic [15:0] lfsr_q, lfsr_d, lfsr_adv;
  logic [CW-1:0] serr_q, serr_d, berr_q, berr_d, word_q, word_d;
  logic [CW:0] bsum;
  logic done_q, done_d, valid_q, valid_d, err_q, err_d, corrupt, elig, trig;
  logic [W-1:0] sym_q, sym_d;
  assign lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign elig = bus.valid_i && (32'(word_q) < WINDOW);
  assign trig = &lfsr_q[N-1:0];
  assign bsum = {1'b0, berr_q} + (CW+1)'($countones(bus.err_mask_i));
  always_comb begin
    st_d = st_q;
    rem_d = rem_q;
    phase_d = phase_q;
    lfsr_d = lfsr_q;
    serr_d = serr_q;
    berr_d = berr_q;
    word_d = word_q;
    corrupt = 1'b0;
    if (bus.clear_i) begin
      st_d = IDLE;
      rem_d = '0;
      phase_d = '0;
      lfsr_d = SEED_V;
      serr_d = '0;
      berr_d = '0;
      word_d = '0;
    end else if (bus.valid_i) begin
      lfsr_d = lfsr_adv;
      if (bus.mode_i != 2'b11) phase_d = '0;
      // leaving burst mode drops any burst in progress
      if (bus.mode_i != 2'b10) begin
        st_d = IDLE;
        rem_d = '0;
      end
      if (bus.mode_i == 2'b01) corrupt = elig && trig;
      if (bus.mode_i == 2'b10 && st_q == BURST && elig) begin
        corrupt = 1'b1;
        rem_d = rem_q - 8'd1;
        st_d = (rem_q == 8'd1) ? IDLE : BURST;
      end
      if (bus.mode_i == 2'b10 && st_q == IDLE && elig && trig) begin
        corrupt = 1'b1;
        rem_d = (bus.burst_len_i == 8'd0) ? 8'd0 : bus.burst_len_i - 8'd1;
        st_d = (rem_d != 8'd0) ? BURST : IDLE;
      end
      // phase wraps on >= so a shrinking period_i cannot strand it above the limit
      if (bus.mode_i == 2'b11 && elig && bus.period_i != 8'd0) begin
        corrupt = (phase_q == bus.period_i - 8'd1);
        phase_d = (phase_q >= bus.period_i - 8'd1) ? 8'd0 : phase_q + 8'd1;
      end
      if (elig && word_q != '1) word_d = word_q + 1'b1;
      if (corrupt && serr_q != '1) serr_d = serr_q + 1'b1;
      if (corrupt) berr_d = bsum[CW] ? '1 : bsum[CW-1:0];
    end
  end
  assign valid_d = bus.valid_i;
  assign sym_d = bus.valid_i ? bus.sym_i ^ (corrupt ? bus.err_mask_i : '0) : '0;
  assign err_d = corrupt;
  assign done_d = !bus.clear_i && (done_q || 32'(word_d) == WINDOW);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= IDLE;
      rem_q <= '0;
      phase_q <= '0;
      lfsr_q <= SEED_V;
      serr_q <= '0;
      berr_q <= '0;
      word_q <= '0;
      done_q <= 1'b0;
      valid_q <= 1'b0;
      sym_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      rem_q <= rem_d;
      phase_q <= phase_d;
      lfsr_q <= lfsr_d;
      serr_q <= serr_d;
      berr_q <= berr_d;
      word_q <= word_d;
      done_q <= done_d;
      valid_q <= valid_d;
      sym_q <= sym_d;
      err_q <= err_d;
    end
  assign bus.valid_o = valid_q;
  assign bus.sym_o = sym_q;
  assign bus.err_o = err_q;
  assign bus.sym_err_ct_o = serr_q;
  assign bus.bit_err_ct_o = berr_q;
  assign bus.word_ct_o = word_q;
  assign bus.window_done_o = done_q;
endmodule

// File: doc/conv_channel_injector.md
# conv_channel_injector

- Parametrised channel model between the convolutional encoder and the Viterbi decoder.
- Registers each encoder output symbol and corrupts it under one of four modes: clean, random, random-triggered burst, or fixed-period.
- The corruption pattern is a programmable bit mask. Injection is limited to a measurement window.
- Keeps saturating symbol-error, bit-error and word counters, so channel error statistics come from hardware rather than bench bookkeeping.

## Interface
- W, 2, symbol width (encoder output bits per symbol)
- N, 4, random trigger rate: a trigger fires when LFSR[N-1:0] is all ones (probability 2^-N per symbol); 1..16
- WINDOW, 256, number of valid symbols eligible for injection after reset/clear
- CW, 16, width of statistics counters
- SEED, 16'hACE1, LFSR reset value; a zero value is replaced by 16'hACE1

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- valid_i  in  1  input symbol valid (encoder valid)
- sym_i  in  W  encoder output symbol
- mode_i  in  2  00 clean, 01 random, 10 burst, 11 periodic
- err_mask_i  in  W  bits XORed into a corrupted symbol
- burst_len_i  in  8  burst length in symbols (0 treated as 1)
- period_i  in  8  periodic-mode spacing in symbols (0 = never inject)
- clear_i  in  1  synchronous clear of counters, window, FSM, LFSR, phase
- valid_o  out  1  output symbol valid (decoder enable)
- sym_o  out  W  channel output symbol
- err_o  out  1  high with valid_o when sym_o was corrupted
- sym_err_ct_o  out  CW  corrupted symbols in window, saturating
- bit_err_ct_o  out  CW  flipped bits in window, saturating
- word_ct_o  out  CW  valid symbols seen, saturating at WINDOW
- window_done_o  out  1  sticky, high once word_ct_o == WINDOW

## Operation
- Reset values:
  - valid_o, sym_o, err_o, all counters and window_done_o = 0.
  - FSM = IDLE, phase = 0, LFSR = SEED.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances exactly once per cycle with valid_i=1. The trigger test uses the pre-advance value.
- Eligibility: a symbol is eligible when valid_i=1 and word_ct_o < WINDOW.
  - Ineligible valid symbols pass unmodified.
  - The LFSR still advances on ineligible valid symbols.
- Mode 00: never corrupt.
- Mode 01: corrupt an eligible symbol when the trigger fires.
- Mode 10, two-state FSM:
  - IDLE: on an eligible trigger, corrupt the symbol and load rem = max(burst_len_i,1)-1. Go to BURST if rem≠0.
  - BURST: corrupt each eligible symbol and decrement rem. Return to IDLE when rem reaches 0.
  - burst_len_i is sampled only at burst start.
  - If mode_i leaves 10 while in BURST, the FSM goes to IDLE on the next valid symbol. That symbol is handled per the new mode.
- Mode 11:
  - phase counts eligible symbols modulo period_i.
  - Corrupt when phase == period_i-1, so the first corruption is the period_i-th symbol.
  - phase resets to 0 when mode_i≠11.
- Corruption: sym_o = sym_i ^ err_mask_i.
  - err_o reflects corruption decided, even if err_mask_i = 0.
  - bit_err_ct_o adds popcount(err_mask_i) on each corrupted symbol.
- Counters:
  - Counters saturate at 2^CW-1 and never wrap.
  - word_ct_o also stops at WINDOW. It equals WINDOW on the cycle after the WINDOW-th symbol, and window_done_o rises in that same cycle.
- clear_i:
  - Returns every state element to its reset value, except valid_o/sym_o, which still register the current input.
  - On the clear cycle the input symbol passes clean and is not counted.
  - clear_i has priority over all other updates.

## Timing
- Latency: one cycle, valid_i→valid_o and sym_i→sym_o. There is no backpressure.
- valid_o=0 cycles: sym_o and err_o hold 0. Counters, LFSR, FSM and phase hold.
- Counters update in the same edge as the corresponding sym_o/err_o.
- mode_i, err_mask_i and period_i are sampled per valid symbol. Changes take effect on the next valid symbol.
- Reset asserted mid-burst or mid-window: all state clears immediately and asynchronously. Operation restarts from SEED on the first valid symbol after deassertion.

## Test plan
- **Clean pass-through.** Mode 00, 300 consecutive valid symbols, counting pattern.
  - sym_o equals sym_i delayed one cycle, err_o never high.
  - Error counters = 0, word_ct_o = 256, window_done_o rises after the 256th symbol.
- **Periodic mode.** Mode 11, period_i=4, mask 2'b11, 300 symbols.
  - Symbols 4,8,…,256 inverted; symbols 257–300 clean.
  - sym_err_ct_o = 64, bit_err_ct_o = 128.
- **Random and burst vs. bench LFSR model.**
  - Mode 01, N=4, mask 2'b01: every trigger corrupts only bit 0, and err_o matches the model exactly.
  - Mode 10, burst_len_i=5: each trigger yields exactly 5 consecutive corrupted valid symbols, including across valid_i gaps.
- **Burst boundaries.**
  - burst_len_i=0 gives single-symbol corruption.
  - Switching to mode 00 mid-burst: the next symbol is clean and the FSM is IDLE.
  - A burst still active at symbol 256: symbol 257 onward is clean.
- **Saturation.** CW=4, WINDOW=15, mode 11, period_i=1, mask 2'b11, 20 symbols.
  - sym_err_ct_o = 15, bit_err_ct_o = 15, word_ct_o = 15, none wrap.
- **Clear and reset mid-operation.**
  - clear_i pulse after 100 symbols: counters return to 0 and the LFSR error sequence restarts identical to the post-reset one.
  - rst low during a burst: all outputs read 0 within the same cycle.
